// File: rtl/register_trace_capture.sv
// Register write-back trace capture: timestamps CPU register writes into a
// first-word-fall-through FIFO drained over a valid/ready port.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for CaptureEn; writes ignored, stamp held
// CAPTURE | writes pushed with current stamp; stamp advances every cycle
// DRAIN   | halt seen; writes ignored, consumer empties the FIFO
// DONE    | FIFO drained after halt; held until sync_rst
module register_trace_capture #(
    parameter int DATABITWIDTH    = 16,
    parameter int REGADDRBITWIDTH = 4,
    parameter int DEPTH           = 8,
    parameter int STAMPBITWIDTH   = 16,
    parameter int DROPBITWIDTH    = 8
) (
    input  logic                       clk,
    input  logic                       sync_rst,
    input  logic                       clk_en,
    input  logic                       CaptureEn,
    input  logic                       HaltIn,
    input  logic                       RegisterWriteEn_IN,
    input  logic [REGADDRBITWIDTH-1:0] RegisterWriteAddr_IN,
    input  logic [DATABITWIDTH-1:0]    RegisterWriteData_IN,
    output logic                       TraceValid,
    input  logic                       TraceReady,
    output logic [REGADDRBITWIDTH-1:0] TraceAddr,
    output logic [DATABITWIDTH-1:0]    TraceData,
    output logic [STAMPBITWIDTH-1:0]   TraceStamp,
    output logic                       Overflow,
    output logic [DROPBITWIDTH-1:0]    DropCount,
    output logic                       Capturing,
    output logic                       Drained
);
    localparam int PTRW = $clog2(DEPTH);
    localparam int CNTW = PTRW + 1;
    localparam int ENTW = REGADDRBITWIDTH + DATABITWIDTH + STAMPBITWIDTH;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CAPTURE = 2'd1;
    localparam logic [1:0] ST_DRAIN   = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    logic [1:0]               state;
    logic [ENTW-1:0]          mem [DEPTH];
    logic [PTRW-1:0]          wr_ptr;
    logic [PTRW-1:0]          rd_ptr;
    logic [CNTW-1:0]          count;
    logic [STAMPBITWIDTH-1:0] stamp;
    logic                     full;
    logic                     pop;
    logic                     push_req;
    logic                     push;
    logic                     drop;

    assign full       = (count == CNTW'(DEPTH));
    assign TraceValid = (count != '0);
    assign pop        = TraceValid && TraceReady && clk_en;
    assign push_req   = clk_en && RegisterWriteEn_IN && (state == ST_CAPTURE);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push       = push_req && (!full || pop);
    assign drop       = push_req && full && !pop;

    assign {TraceAddr, TraceData, TraceStamp} = mem[rd_ptr];
    assign Capturing = (state == ST_CAPTURE);
    assign Drained   = (state == ST_DONE);

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            state     <= ST_IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            stamp     <= '0;
            Overflow  <= 1'b0;
            DropCount <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clk_en) begin
            if (push) begin
                mem[wr_ptr] <= {RegisterWriteAddr_IN, RegisterWriteData_IN, stamp};
                wr_ptr      <= wr_ptr + PTRW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTRW'(1);
            end
            if (push && !pop) begin
                count <= count + CNTW'(1);
            end else if (!push && pop) begin
                count <= count - CNTW'(1);
            end
            if (drop) begin
                Overflow <= 1'b1;
                if (DropCount != '1) begin
                    DropCount <= DropCount + DROPBITWIDTH'(1);
                end
            end
            case (state)
                ST_IDLE: begin
                    if (CaptureEn) begin
                        state <= ST_CAPTURE;
                        stamp <= '0;
                    end
                end
                ST_CAPTURE: begin
                    stamp <= stamp + STAMPBITWIDTH'(1);
                    if (HaltIn) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!TraceValid) begin
                        state <= ST_DONE;
                    end
                end
                default: state <= ST_DONE;
            endcase
        end
    end
endmodule

// File: doc/register_trace_capture.md
# register_trace_capture

Captures the CPU's register write-back events (enable, address, data) into a first-word-fall-through FIFO. Each entry is tagged with a capture-relative timestamp, and the FIFO is drained through a valid/ready port. The block sits beside the CPU top level as the consumer of its register write-back trace port, giving benches and the debug path a lossless-or-counted record of architectural writes up to halt.

## Interface
- DATABITWIDTH, 16, width of register write data
- REGADDRBITWIDTH, 4, width of register address
- DEPTH, 8, FIFO entries; power of two, at least 2
- STAMPBITWIDTH, 16, timestamp counter width
- DROPBITWIDTH, 8, dropped-event counter width
- clk  in  1  system clock; all state updates on the rising edge
- sync_rst  in  1  reset, synchronous, active-high; acts regardless of clk_en
- clk_en  in  1  global clock enable; no state changes when low, except reset
- CaptureEn  in  1  level; arms capture from IDLE
- HaltIn  in  1  CPU halt indication
- RegisterWriteEn_IN  in  1  write-back strobe
- RegisterWriteAddr_IN  in  REGADDRBITWIDTH  write-back address
- RegisterWriteData_IN  in  DATABITWIDTH  write-back data
- TraceValid  out  1  FIFO head is valid
- TraceReady  in  1  consumer accepts the head
- TraceAddr  out  REGADDRBITWIDTH  head address
- TraceData  out  DATABITWIDTH  head data
- TraceStamp  out  STAMPBITWIDTH  head timestamp
- Overflow  out  1  sticky; at least one event was dropped
- DropCount  out  DROPBITWIDTH  dropped events, saturating
- Capturing  out  1  state is CAPTURE
- Drained  out  1  state is DONE

## Operation
- States:
  - IDLE -> CAPTURE when CaptureEn=1.
  - CAPTURE -> DRAIN when HaltIn=1.
  - DRAIN -> DONE when the FIFO is empty and no pop occurs this cycle.
  - DONE holds until sync_rst.
- All transitions and updates require clk_en=1.
- Stamp counter: cleared to 0 on the IDLE->CAPTURE transition. Increments by 1 each clk_en cycle while in CAPTURE and wraps modulo 2^STAMPBITWIDTH.
- Push: RegisterWriteEn_IN=1 in CAPTURE, including the cycle HaltIn rises. The entry stores {addr, data, current stamp value before increment}. Writes in IDLE, DRAIN or DONE are ignored and not counted as drops.
- Pop: TraceValid && TraceReady && clk_en. Pops are allowed in every state.
- Full FIFO:
  - A push succeeds only if a pop occurs in the same cycle.
  - Otherwise the push is dropped: Overflow is set and DropCount increments, saturating at all-ones.
- Empty FIFO with simultaneous push and pop: no bypass. TraceValid is low that cycle, so no pop occurs and the push is stored.
- Occupancy counter width is clog2(DEPTH)+1. Read and write pointers wrap modulo DEPTH.
- Trace outputs come from registered storage at the read pointer. They are don't-care when TraceValid=0, and the bench checks them only when valid.
- sync_rst mid-operation:
  - FIFO is flushed; state returns to IDLE.
  - Stamp, Overflow and DropCount are cleared.
  - Any in-flight push or pop that cycle is discarded.

## Timing
- Reset values: TraceValid=0, Overflow=0, DropCount=0, Capturing=0, Drained=0, TraceAddr/TraceData/TraceStamp=0.
- Push-to-visible latency: a push sampled at edge N drives TraceValid=1 with the entry on the outputs after edge N.
- The first write can occur in the same clk_en cycle CaptureEn is seen. It is not captured, because the state is still IDLE. Capture starts on the next cycle, with stamp 0.
- Capturing rises one edge after the IDLE->CAPTURE transition condition and falls one edge after HaltIn is sampled.
- With clk_en=0, TraceValid and the outputs hold their values. A TraceReady high during clk_en=0 does not pop.
- Sustained throughput: one push and one pop per clk_en cycle.

## Test plan
- Basic order: reset, CaptureEn=1, then writes (3,0x1111), (5,0x2222), (3,0x3333) on consecutive cycles with TraceReady=0. Expect 3 entries in order with stamps 0, 1, 2. Then TraceReady=1 pops them on three consecutive cycles.
- Overflow: with DEPTH=8 and TraceReady=0, issue 10 consecutive writes. Expect 8 entries (stamps 0..7), Overflow=1, DropCount=2. Then one full-plus-pop cycle: a write with TraceReady=1 is accepted and DropCount stays 2.
- Halt/drain: 2 writes, then HaltIn=1 together with a third write, then a write in DRAIN. Expect 3 entries and Capturing=0. Drained=1 only after the third pop, on the following edge; the DRAIN write is ignored.
- clk_en gating: hold clk_en=0 for 4 cycles while RegisterWriteEn_IN=1 and TraceReady=1. Expect no push, no pop, stamp frozen, outputs stable.
- Reset mid-capture: 5 entries queued with Overflow=1, then assert sync_rst with clk_en=0. Expect TraceValid=0, Overflow=0, DropCount=0, state IDLE on the next edge.
- Stamp wrap: STAMPBITWIDTH=4 with a write every 5th cycle over 20 cycles. Expect stamps 0, 5, 10, 15, 4.
